div_unit: RTL and testbench

Iterative radix-2 restoring divider implementing the RV32M DIV, DIVU, REM and REMU instructions for the multicycle core. It sits between the operand registers (rs1/rs2 flops) and the ALU result mux. It accepts a request while idle, computes for a fixed number of cycles, and presents a registered result with a one-cycle ready pulse. The control FSM stalls in its execute state until that pulse arrives.

---
 rtl/div_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_div_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// A request is taken only while idle. The unit then runs WIDTH shift/subtract
// iterations (one per clock), applies the special-case and sign fix-ups in a
// single FIX cycle, and presents a registered result with a one-cycle ready
// pulse. The result holds until the next accepted request completes.
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   defined   - divide-by-zero and signed-overflow requests skip the
//               iterations and go straight to FIX (ready one cycle after
//               the cycle in which the request is accepted).
//   undefined - every request runs all WIDTH iterations.
//
// Ports:
//   clk       rising-edge clock
//   resetn    synchronous active-low reset; aborts any in-flight operation
//   valid     request strobe, sampled only while idle
//   op        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  rs1 operand
//   divisor   rs2 operand
//   result    quotient or remainder (registered)
//   ready     one-cycle pulse, result valid
//   busy      high whenever the unit is not idle (registered)
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO     = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Two's complement negation, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;       // dividend magnitude, shifted into quotient
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic [WIDTH-1:0] orig_q, orig_d;     // raw dividend, needed for REM by zero
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sel_rem_q, sel_rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             req_signed_s;
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic             req_div0_s;
  logic             req_ovf_s;
  logic [WIDTH:0]   shifted_s;          // {rem, quo} shifted left: upper WIDTH+1 bits
  logic [WIDTH+1:0] trial_s;            // WIDTH+1-bit subtract plus borrow bit
  logic             unused_trial_s;

  // Request decode from the raw operands (only meaningful while idle).
  always_comb begin
    req_signed_s = ~op[0];
    dvd_neg_s    = req_signed_s & dividend[WIDTH-1];
    dvs_neg_s    = req_signed_s & divisor[WIDTH-1];
    req_div0_s   = (divisor == ZERO);
    req_ovf_s    = req_signed_s & (dividend == MIN_NEG) & (divisor == ALL_ONES);
  end

  // Trial subtraction; a set top bit means the shifted remainder was smaller than the divisor.
  always_comb begin
    shifted_s = {rem_q, quo_q[WIDTH-1]};
    trial_s   = {1'b0, shifted_s} - {2'b00, dvs_q};
  end

  // When no borrow occurs the difference is below the divisor, so bit WIDTH is always zero.
  assign unused_trial_s = trial_s[WIDTH];

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    orig_d    = orig_q;
    cnt_d     = cnt_q;
    sel_rem_d = sel_rem_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    ready_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          quo_d     = dvd_neg_s ? neg2c(dividend) : dividend;
          dvs_d     = dvs_neg_s ? neg2c(divisor) : divisor;
          orig_d    = dividend;
          rem_d     = ZERO;
          cnt_d     = CNT_ZERO;
          sel_rem_d = op[1];
          q_neg_d   = dvd_neg_s ^ dvs_neg_s;
          r_neg_d   = dvd_neg_s;
          div0_d    = req_div0_s;
          ovf_d     = req_ovf_s;
`ifdef DIV_EARLY_OUT_EN
          state_d   = (req_div0_s | req_ovf_s) ? S_FIX : S_CALC;
`else
          state_d   = S_CALC;
`endif
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_CALC: begin
        if (trial_s[WIDTH+1]) begin
          rem_d = shifted_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = trial_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_CALC;
        end
      end

      S_FIX: begin
        if (div0_q) begin
          result_d = sel_rem_q ? orig_q : ALL_ONES;
        end else if (ovf_q) begin
          result_d = sel_rem_q ? ZERO : MIN_NEG;
        end else if (sel_rem_q) begin
          result_d = r_neg_q ? neg2c(rem_q) : rem_q;
        end else begin
          result_d = q_neg_q ? neg2c(quo_q) : quo_q;
        end
        ready_d = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      quo_q     <= ZERO;
      rem_q     <= ZERO;
      dvs_q     <= ZERO;
      orig_q    <= ZERO;
      cnt_q     <= CNT_ZERO;
      sel_rem_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= ZERO;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      orig_q    <= orig_d;
      cnt_q     <= cnt_d;
      sel_rem_q <= sel_rem_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (WIDTH = 32).
// A behavioural model computes each result with plain integer division and
// the RV32M special cases, and tracks when ready/busy must be seen; a single
// compare process checks busy, ready and result on every falling edge.
// Directed vectors additionally check hand-computed results and latencies.
module tb_div_unit;

  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         valid = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] dividend = 32'h0;
  logic [W-1:0] divisor = 32'h0;
  logic [W-1:0] result;
  logic         ready;
  logic         busy;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .valid    (valid),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .ready    (ready),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_pulses = 0;
  bit chk_en = 1'b0;

  // model state
  bit           m_busy = 1'b0;
  int           m_done_at = 0;
  logic [W-1:0] m_res = 32'h0;
  logic [W-1:0] m_next = 32'h0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M semantics with plain arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [W-1:0] r;
    if (b == 32'h0) begin
      r = o[1] ? a : 32'hFFFF_FFFF;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = o[1] ? 32'h0 : 32'h8000_0000;
    end else if (!o[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = o[1] ? W'(sa % sb) : W'(sa / sb);
    end else begin
      r  = o[1] ? (a % b) : (a / b);
    end
    return r;
  endfunction

  function automatic int lat_of(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 32'h0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return SP_LAT;
    return 33;
  endfunction

  // Model: acceptance, completion time and the held result.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn) begin
      m_busy <= 1'b0;
      m_res  <= 32'h0;
    end else if (!m_busy && valid) begin
      m_busy    <= 1'b1;
      m_done_at <= cyc + 1 + lat_of(op, dividend, divisor);
      m_next    <= model(op, dividend, divisor);
    end else if (m_busy && (cyc + 1 == m_done_at + 1)) begin
      m_busy <= 1'b0;
    end
    if (resetn && m_busy && (cyc + 1 == m_done_at)) m_res <= m_next;
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_bit("cyc_busy", busy, m_busy);
      check_bit("cyc_ready", ready, m_busy && (cyc == m_done_at));
      check("cyc_result", result, m_res);
      if (ready === 1'b1) rdy_pulses++;
    end
  end

  // Wait (bounded) for ready; returns latency relative to acceptance cycle k0.
  task automatic wait_ready(input string name, input int k0, output int lat, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    lat = cyc - k0;
    check_bit({name, "_ready_seen"}, seen, 1'b1);
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat);
    int k0, lat;
    bit seen;
    @(negedge clk);
    valid = 1'b1; op = o; dividend = a; divisor = b;
    @(negedge clk);
    valid = 1'b0;
    k0 = cyc;
    wait_ready(name, k0, lat, seen);
    if (seen) begin
      check({name, "_result"}, result, exp_res);
      check_int({name, "_latency"}, lat, exp_lat);
    end
    @(negedge clk);
  endtask

  initial begin
    int k0, k1, lat, p0;
    bit seen;

    resetn = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_result", result, 32'h0);
    check_bit("reset_ready", ready, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    resetn = 1'b1;

    run("divu_100_7",  2'b01, 32'd100, 32'd7, 32'd14, 33);
    check_bit("busy_after_ready", busy, 1'b0);
    run("remu_100_7",  2'b11, 32'd100, 32'd7, 32'd2, 33);
    run("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("div_7_m2",    2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run("rem_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run("divu_big",    2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
    run("remu_big",    2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
    run("div_5_0",     2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, SP_LAT);
    run("divu_5_0",    2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, SP_LAT);
    run("rem_5_0",     2'b10, 32'd5, 32'd0, 32'd5, SP_LAT);
    run("remu_5_0",    2'b11, 32'd5, 32'd0, 32'd5, SP_LAT);
    run("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SP_LAT);
    run("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SP_LAT);
    run("divu_nonovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // valid held high with changing operands while busy
    @(negedge clk);
    valid = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd10;
    @(negedge clk);
    k0 = cyc;
    p0 = rdy_pulses;
    for (int i = 0; i < 20; i++) begin
      op       = 2'($urandom_range(0, 3));
      dividend = $urandom;
      divisor  = $urandom_range(1, 1000);
      @(negedge clk);
    end
    valid = 1'b0;
    wait_ready("hold", k0, lat, seen);
    if (seen) begin
      check("hold_result", result, 32'd100);
      check_int("hold_latency", lat, 33);
    end
    repeat (5) @(negedge clk);
    check_int("hold_pulses", rdy_pulses - p0, 1);
    check_bit("hold_idle", busy, 1'b0);

    // back-to-back: second request waits until after DONE
    @(negedge clk);
    valid = 1'b1; op = 2'b01; dividend = 32'd77; divisor = 32'd7;
    @(negedge clk);
    k0 = cyc;
    dividend = 32'd200; divisor = 32'd8;
    wait_ready("b2b_first", k0, lat, seen);
    if (seen) begin
      check("b2b_first_result", result, 32'd11);
      check_int("b2b_first_latency", lat, 33);
    end
    @(negedge clk);
    check_bit("b2b_gap_busy", busy, 1'b0);
    @(negedge clk);
    check_bit("b2b_second_busy", busy, 1'b1);
    valid = 1'b0;
    k1 = cyc;
    @(negedge clk);
    wait_ready("b2b_second", k1, lat, seen);
    if (seen) begin
      check("b2b_second_result", result, 32'd25);
      check_int("b2b_second_latency", lat, 33);
    end
    @(negedge clk);

    // reset mid-operation
    @(negedge clk);
    valid = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd10;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_ready", ready, 1'b0);
    check("abort_result", result, 32'h0);
    resetn = 1'b1;
    p0 = rdy_pulses;
    repeat (40) @(negedge clk);
    check_int("abort_no_pulse", rdy_pulses - p0, 0);
    run("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
